// File: rtl/ex_muldiv_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_iter
// Purpose  : Iterative RV32M multiply/divide unit (shift-add / restoring).
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_iter #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            start_valid,
   output logic            start_ready,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   input  logic [4:0]      rd_in,
   output logic            result_valid,
   input  logic            result_ready,
   output logic [XLEN-1:0] result,
   output logic [4:0]      result_rd,
   output logic            busy
);

   localparam int c_ITER  = XLEN / UNROLL;
   localparam int c_CNT_W = (c_ITER > 1) ? $clog2(c_ITER) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_ITER - 1);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_CALC = 2'd1;
   localparam logic [1:0] c_FIX  = 2'd2;
   localparam logic [1:0] c_DONE = 2'd3;

   logic [1:0]          r_state, w_next;
   logic [2:0]          r_funct3;
   logic [4:0]          r_rd;
   logic                r_neg;
   logic [XLEN-1:0]     r_op2;
   logic [2*XLEN-1:0]   r_acc;
   logic [XLEN:0]       r_rem;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [XLEN-1:0]     r_result;

   logic                w_accept, w_special, w_div0, w_ovf;
   logic                w_sgn1, w_sgn2, w_s1, w_s2, w_neg;
   logic [XLEN-1:0]     w_mag1, w_mag2, w_special_val;

   assign w_accept = start_valid & (r_state == c_IDLE) & ~flush;

   // Operand signedness and magnitudes, decoded from the incoming funct3.
   assign w_sgn1 = (funct3 == 3'b001) | (funct3 == 3'b010) |
                   (funct3 == 3'b100) | (funct3 == 3'b110);
   assign w_sgn2 = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
   assign w_s1   = w_sgn1 & operand1[XLEN-1];
   assign w_s2   = w_sgn2 & operand2[XLEN-1];
   assign w_mag1 = w_s1 ? (~operand1 + 1'b1) : operand1;
   assign w_mag2 = w_s2 ? (~operand2 + 1'b1) : operand2;
   // Remainders follow the dividend; everything else follows the product/quotient sign.
   assign w_neg  = (funct3[2] & funct3[1]) ? w_s1 : (w_s1 ^ w_s2);

   assign w_div0 = (operand2 == '0);
   assign w_ovf  = ~funct3[0] & (operand1 == {1'b1, {(XLEN-1){1'b0}}}) &
                   (operand2 == {XLEN{1'b1}});
   assign w_special = funct3[2] & (w_div0 | w_ovf);
   always_comb begin
      w_special_val = '0;
      if (w_div0)
         w_special_val = funct3[1] ? operand1 : {XLEN{1'b1}};
      else
         w_special_val = funct3[1] ? '0 : operand1;
   end

   // UNROLL iterations of both shift-add and restoring division per cycle.
   logic [2*XLEN-1:0] w_mul_p;
   logic [XLEN:0]     w_sum;
   logic [XLEN-1:0]   w_div_q;
   logic [XLEN:0]     w_div_r;
   logic [XLEN:0]     w_shift;
   logic [XLEN+1:0]   w_diff;

   always_comb begin
      w_mul_p = r_acc;
      w_div_q = r_acc[XLEN-1:0];
      w_div_r = r_rem;
      w_sum   = '0;
      w_shift = '0;
      w_diff  = '0;
      for (int i = 0; i < UNROLL; i++) begin
         w_sum   = {1'b0, w_mul_p[2*XLEN-1:XLEN]} +
                   (w_mul_p[0] ? {1'b0, r_op2} : {(XLEN+1){1'b0}});
         w_mul_p = {w_sum, w_mul_p[XLEN-1:1]};
         w_shift = {w_div_r[XLEN-1:0], w_div_q[XLEN-1]};
         w_diff  = {1'b0, w_shift} - {2'b00, r_op2};
         w_div_r = w_diff[XLEN+1] ? w_shift : w_diff[XLEN:0];
         w_div_q = {w_div_q[XLEN-2:0], ~w_diff[XLEN+1]};
      end
   end

   logic [2*XLEN-1:0] w_prod_fix;
   logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_fix_val;

   assign w_prod_fix = r_neg ? (~r_acc + 1'b1) : r_acc;
   assign w_quo_fix  = r_neg ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
   assign w_rem_fix  = r_neg ? (~r_rem[XLEN-1:0] + 1'b1) : r_rem[XLEN-1:0];

   always_comb begin
      w_fix_val = '0;
      case (r_funct3)
         3'b000:                 w_fix_val = r_acc[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_fix_val = w_prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_fix_val = w_quo_fix;
         default:                w_fix_val = w_rem_fix;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= c_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE:  if (w_accept) w_next = w_special ? c_DONE : c_CALC;
         c_CALC:  if (r_cnt == c_LAST) w_next = c_FIX;
         c_FIX:   w_next = c_DONE;
         c_DONE:  if (result_ready) w_next = c_IDLE;
         default: w_next = c_IDLE;
      endcase
      if (flush)
         w_next = c_IDLE;
   end

   always_comb begin
      start_ready  = 1'b0;
      busy         = 1'b1;
      result_valid = 1'b0;
      case (r_state)
         c_IDLE: begin
            start_ready = 1'b1;
            busy        = 1'b0;
         end
         c_DONE:  result_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_funct3 <= '0;
         r_rd     <= '0;
         r_neg    <= 1'b0;
         r_op2    <= '0;
         r_acc    <= '0;
         r_rem    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_funct3 <= funct3;
         r_rd     <= rd_in;
         r_neg    <= w_neg;
         r_op2    <= w_mag2;
         r_acc    <= {{XLEN{1'b0}}, w_mag1};
         r_rem    <= '0;
         r_cnt    <= '0;
         if (w_special)
            r_result <= w_special_val;
      end else if (r_state == c_CALC) begin
         r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
         if (r_funct3[2]) begin
            r_acc[XLEN-1:0] <= w_div_q;
            r_rem           <= w_div_r;
         end else begin
            r_acc <= w_mul_p;
         end
      end else if (r_state == c_FIX) begin
         r_result <= w_fix_val;
      end
   end

   assign result    = r_result;
   assign result_rd = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_iter
// Purpose  : Directed self-checking bench for ex_muldiv_iter (UNROLL 1 and 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_iter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, start_valid, start_ready, result_valid, result_ready, busy;
   logic [2:0]  funct3;
   logic [31:0] operand1, operand2, result;
   logic [4:0]  rd_in, result_rd;

   logic        rst4, flush4, start_valid4, start_ready4, result_valid4, result_ready4, busy4;
   logic [2:0]  funct3_4;
   logic [31:0] operand1_4, operand2_4, result4;
   logic [4:0]  rd_in4, result_rd4;

   int n_checks = 0;
   int n_errors = 0;

   ex_muldiv_iter #(.XLEN(32), .UNROLL(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .start_valid(start_valid),
      .start_ready(start_ready), .funct3(funct3), .operand1(operand1),
      .operand2(operand2), .rd_in(rd_in), .result_valid(result_valid),
      .result_ready(result_ready), .result(result), .result_rd(result_rd), .busy(busy)
   );

   ex_muldiv_iter #(.XLEN(32), .UNROLL(4)) dut4 (
      .clk(clk), .rst(rst4), .flush(flush4), .start_valid(start_valid4),
      .start_ready(start_ready4), .funct3(funct3_4), .operand1(operand1_4),
      .operand2(operand2_4), .rd_in(rd_in4), .result_valid(result_valid4),
      .result_ready(result_ready4), .result(result4), .result_rd(result_rd4), .busy(busy4)
   );

   // Drives one request on the UNROLL=1 unit, returns result and accept-to-valid latency.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res,
                         output logic [4:0] res_rd, output int lat);
      funct3 = f; operand1 = a; operand2 = b; rd_in = rd; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      lat = 1;
      while (!result_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      res = result; res_rd = result_rd;
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rst4 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({start_ready, busy, result_valid, result_rd, result} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
         n_errors++;
         $display("FAIL reset_state: got rdy=%b busy=%b vld=%b rd=%0d res=%h, want 1 0 0 0 0",
                  start_ready, busy, result_valid, result_rd, result);
      end
      rst = 1'b0; rst4 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
      logic [31:0] r; logic [4:0] rr; int lat;
      run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, r, rr, lat);
      n_checks++;
      if (r !== 32'hFFFFFFFE || rr !== 5'd3) begin
         n_errors++; $display("FAIL mulhu: got %h rd %0d, want fffffffe rd 3", r, rr);
      end
      n_checks++;
      if (lat !== 34) begin
         n_errors++; $display("FAIL mulhu_latency: got %0d, want 34", lat);
      end
      run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, r, rr, lat);
      n_checks++;
      if (r !== 32'h00000001) begin
         n_errors++; $display("FAIL mul: got %h, want 00000001", r);
      end
   endtask

   task automatic test_signed();
      logic [31:0] r; logic [4:0] rr; int lat;
      run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, r, rr, lat);
      n_checks++;
      if (r !== 32'h00000000) begin
         n_errors++; $display("FAIL mulh: got %h, want 00000000", r);
      end
      run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, r, rr, lat);
      n_checks++;
      if (r !== 32'hFFFFFFFF) begin
         n_errors++; $display("FAIL mulhsu: got %h, want ffffffff", r);
      end
      run_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd5, r, rr, lat);
      n_checks++;
      if (r !== 32'hFFFFFFFD || lat !== 34) begin
         n_errors++; $display("FAIL div_neg: got %h lat %0d, want fffffffd lat 34", r, lat);
      end
      run_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd6, r, rr, lat);
      n_checks++;
      if (r !== 32'hFFFFFFFF) begin
         n_errors++; $display("FAIL rem_neg: got %h, want ffffffff", r);
      end
   endtask

   task automatic test_special();
      logic [31:0] r; logic [4:0] rr; int lat;
      run_op(3'b101, 32'd7, 32'd0, 5'd7, r, rr, lat);
      n_checks++;
      if (r !== 32'hFFFFFFFF || lat !== 1 || rr !== 5'd7) begin
         n_errors++; $display("FAIL divu_by_zero: got %h lat %0d rd %0d, want ffffffff lat 1 rd 7", r, lat, rr);
      end
      run_op(3'b111, 32'd7, 32'd0, 5'd8, r, rr, lat);
      n_checks++;
      if (r !== 32'd7 || lat !== 1) begin
         n_errors++; $display("FAIL remu_by_zero: got %h lat %0d, want 00000007 lat 1", r, lat);
      end
      run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd9, r, rr, lat);
      n_checks++;
      if (r !== 32'h80000000 || lat !== 1) begin
         n_errors++; $display("FAIL div_overflow: got %h lat %0d, want 80000000 lat 1", r, lat);
      end
      run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd10, r, rr, lat);
      n_checks++;
      if (r !== 32'h00000000 || lat !== 1) begin
         n_errors++; $display("FAIL rem_overflow: got %h lat %0d, want 00000000 lat 1", r, lat);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      funct3 = 3'b000; operand1 = 32'd6; operand2 = 32'd7; rd_in = 5'd17; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      lat = 1;
      while (!result_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      n_checks++;
      if (lat !== 34) begin
         n_errors++; $display("FAIL bp_latency: got %0d, want 34", lat);
      end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if ({result_valid, start_ready, result_rd, result} !== {1'b1, 1'b0, 5'd17, 32'd42}) begin
            n_errors++;
            $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b rd=%0d res=%h, want 1 0 17 0000002a",
                     i, result_valid, start_ready, result_rd, result);
         end
         @(posedge clk); #1;
      end
      result_ready = 1'b1;
      n_checks++;
      if (start_ready !== 1'b0) begin
         n_errors++; $display("FAIL bp_ready_at_handshake: got %b, want 0", start_ready);
      end
      @(posedge clk); #1;
      result_ready = 1'b0;
      n_checks++;
      if (start_ready !== 1'b1 || result_valid !== 1'b0) begin
         n_errors++; $display("FAIL bp_after_handshake: got rdy=%b vld=%b, want 1 0", start_ready, result_valid);
      end
   endtask

   task automatic test_flush();
      logic [31:0] r; logic [4:0] rr; int lat;
      funct3 = 3'b101; operand1 = 32'd1000; operand2 = 32'd3; rd_in = 5'd9; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b1 || result_valid !== 1'b0) begin
         n_errors++; $display("FAIL flush_pre_calc: got busy=%b vld=%b, want 1 0", busy, result_valid);
      end
      flush = 1'b1; start_valid = 1'b1;
      funct3 = 3'b101; operand1 = 32'd50; operand2 = 32'd5; rd_in = 5'd12;
      @(posedge clk); #1;
      flush = 1'b0; start_valid = 1'b0;
      n_checks++;
      if ({start_ready, busy, result_valid} !== 3'b100) begin
         n_errors++; $display("FAIL flush_idle: got rdy=%b busy=%b vld=%b, want 1 0 0", start_ready, busy, result_valid);
      end
      repeat (3) begin
         @(posedge clk); #1;
      end
      n_checks++;
      if (busy !== 1'b0 || result_valid !== 1'b0) begin
         n_errors++; $display("FAIL flush_no_accept: got busy=%b vld=%b, want 0 0", busy, result_valid);
      end
      run_op(3'b101, 32'd100, 32'd7, 5'd11, r, rr, lat);
      n_checks++;
      if (r !== 32'd14 || lat !== 34 || rr !== 5'd11) begin
         n_errors++; $display("FAIL flush_then_divu: got %0d lat %0d rd %0d, want 14 lat 34 rd 11", r, lat, rr);
      end
   endtask

   task automatic test_unroll4_reset();
      int lat;
      funct3_4 = 3'b101; operand1_4 = 32'd100; operand2_4 = 32'd7; rd_in4 = 5'd19; start_valid4 = 1'b1;
      @(posedge clk); #1;
      start_valid4 = 1'b0;
      lat = 1;
      while (!result_valid4 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      n_checks++;
      if (result4 !== 32'd14 || lat !== 10 || result_rd4 !== 5'd19) begin
         n_errors++; $display("FAIL u4_divu: got %0d lat %0d rd %0d, want 14 lat 10 rd 19", result4, lat, result_rd4);
      end
      result_ready4 = 1'b1;
      @(posedge clk); #1;
      result_ready4 = 1'b0;
      // Start a second operation and reset it part-way through CALC.
      funct3_4 = 3'b111; operand1_4 = 32'd1000; operand2_4 = 32'd7; rd_in4 = 5'd21; start_valid4 = 1'b1;
      @(posedge clk); #1;
      start_valid4 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (busy4 !== 1'b1) begin
         n_errors++; $display("FAIL u4_mid_calc_busy: got %b, want 1", busy4);
      end
      rst4 = 1'b1;
      #1;
      n_checks++;
      if ({start_ready4, busy4, result_valid4, result_rd4, result4} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
         n_errors++;
         $display("FAIL u4_async_reset: got rdy=%b busy=%b vld=%b rd=%0d res=%h, want 1 0 0 0 0",
                  start_ready4, busy4, result_valid4, result_rd4, result4);
      end
      @(posedge clk); #1;
      rst4 = 1'b0;
      funct3_4 = 3'b111; operand1_4 = 32'd1000; operand2_4 = 32'd7; rd_in4 = 5'd22; start_valid4 = 1'b1;
      @(posedge clk); #1;
      start_valid4 = 1'b0;
      lat = 1;
      while (!result_valid4 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      n_checks++;
      if (result4 !== 32'd6 || lat !== 10 || result_rd4 !== 5'd22) begin
         n_errors++; $display("FAIL u4_after_reset_remu: got %0d lat %0d rd %0d, want 6 lat 10 rd 22", result4, lat, result_rd4);
      end
      result_ready4 = 1'b1;
      @(posedge clk); #1;
      result_ready4 = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
      funct3 = '0; operand1 = '0; operand2 = '0; rd_in = '0;
      rst4 = 1'b1; flush4 = 1'b0; start_valid4 = 1'b0; result_ready4 = 1'b0;
      funct3_4 = '0; operand1_4 = '0; operand2_4 = '0; rd_in4 = '0;
      test_reset();
      test_mul();
      test_signed();
      test_special();
      test_backpressure();
      test_flush();
      test_unroll4_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
